// File: rtl/brightness_pkg.sv
// Shared types, default sizes and the result saturation helper.
package brightness_pkg;

  localparam int DEPTH_DEF         = 4;
  localparam int PE_DATA_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    FEED,
    DRAIN,
    WRITE,
    DONE_ST
  } sched_state_t;

  function automatic logic [7:0] sat8(input logic [PE_DATA_WIDTH_DEF-1:0] x);
    return (|x[PE_DATA_WIDTH_DEF-1:8]) ? 8'hFF : x[7:0];
  endfunction

endpackage

// File: rtl/brightness_tpu_scheduler_lane_feeder.sv
// Holds the accepted pixel block and presents one lane per cycle to the array.
// Zero latency from lane index to outputs; loads whenever the scheduler accepts a block.
module lane_feeder #(
  parameter int DEPTH         = 4,
  parameter int PE_DATA_WIDTH = 16,
  parameter int KW            = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic [PE_DATA_WIDTH*DEPTH-1:0] blk_data,
  input  logic                       active,
  input  logic [KW-1:0]              k,
  output logic [PE_DATA_WIDTH*DEPTH-1:0] sa_in,
  output logic [DEPTH-1:0]           sa_in_valid
);

  logic [PE_DATA_WIDTH-1:0] in_buf [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) in_buf[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < DEPTH; i++) in_buf[i] <= blk_data[i*PE_DATA_WIDTH +: PE_DATA_WIDTH];
    end
  end

  // Only the selected lane carries data; idle lanes are held at zero.
  always_comb begin
    sa_in       = '0;
    sa_in_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (active && k == KW'(i)) begin
        sa_in[i*PE_DATA_WIDTH +: PE_DATA_WIDTH] = in_buf[i];
        sa_in_valid[i]                          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/brightness_tpu_scheduler.sv
// Frame scheduler for the systolic brightness array: accept block, feed lanes, drain, write results.
// 15 cycles per block at defaults; tpu_ready is a level held only in ARM, so a waiting loader simply holds valid.
module brightness_tpu_scheduler
  import brightness_pkg::*;
#(
  parameter int DEPTH          = DEPTH_DEF,
  parameter int PE_DATA_WIDTH  = PE_DATA_WIDTH_DEF,
  parameter int OUT_ADDR_WIDTH = 6,
  parameter int DRAIN_CYCLES   = 2*DEPTH-1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [7:0]                     bright_offset,
  input  logic [PE_DATA_WIDTH*DEPTH-1:0] blk_data,
  input  logic                           blk_valid,
  input  logic                           blk_last,
  output logic                           tpu_ready,
  output logic [PE_DATA_WIDTH*DEPTH-1:0] sa_in,
  output logic [DEPTH-1:0]               sa_in_valid,
  output logic [PE_DATA_WIDTH-1:0]       sa_weight,
  input  logic [PE_DATA_WIDTH*DEPTH-1:0] sa_out,
  output logic                           wr_en,
  output logic [OUT_ADDR_WIDTH-1:0]      wr_addr,
  output logic [7:0]                     wr_data,
  output logic                           busy,
  output logic                           done
);

  localparam int KW = $clog2(DEPTH);
  localparam int CW = $clog2((DRAIN_CYCLES > DEPTH) ? DRAIN_CYCLES : DEPTH);
  localparam logic [CW-1:0] LAST_LANE  = CW'(DEPTH-1);
  localparam logic [CW-1:0] LAST_DRAIN = CW'(DRAIN_CYCLES-1);

  sched_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [7:0] offset_q;
  logic last_q;
  logic [PE_DATA_WIDTH-1:0] res_buf [DEPTH];
  logic accept;

  assign accept = (state == ARM) && blk_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    tpu_ready = 1'b0;
    wr_en     = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (start) state_n = ARM;
      ARM: begin
        tpu_ready = 1'b1;
        if (blk_valid) state_n = FEED;
      end
      FEED:    if (cnt == LAST_LANE) state_n = DRAIN;
      DRAIN:   if (cnt == LAST_DRAIN) state_n = WRITE;
      WRITE: begin
        wr_en = 1'b1;
        if (cnt == LAST_LANE) state_n = last_q ? DONE_ST : ARM;
      end
      DONE_ST: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // One counter serves as lane index, drain timer and write index; it restarts on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      offset_q <= '0;
      last_q   <= 1'b0;
      wr_addr  <= '0;
      for (int i = 0; i < DEPTH; i++) res_buf[i] <= '0;
    end else begin
      if (state != state_n)
        cnt <= '0;
      else if (state == FEED || state == DRAIN || state == WRITE)
        cnt <= cnt + CW'(1);
      if (state == IDLE && start) begin
        offset_q <= bright_offset;
        wr_addr  <= '0;
      end else if (state == WRITE) begin
        wr_addr <= wr_addr + OUT_ADDR_WIDTH'(1);
      end
      if (accept) last_q <= blk_last;
      if (state == DRAIN && cnt == LAST_DRAIN) begin
        for (int i = 0; i < DEPTH; i++) res_buf[i] <= sa_out[i*PE_DATA_WIDTH +: PE_DATA_WIDTH];
      end
    end
  end

  assign sa_weight = {8'h00, offset_q};
  assign wr_data   = wr_en ? sat8(res_buf[cnt[KW-1:0]]) : 8'h00;

  lane_feeder #(
    .DEPTH         (DEPTH),
    .PE_DATA_WIDTH (PE_DATA_WIDTH),
    .KW            (KW)
  ) u_lane_feeder (
    .clk         (clk),
    .reset       (reset),
    .load        (accept),
    .blk_data    (blk_data),
    .active      (state == FEED),
    .k           (cnt[KW-1:0]),
    .sa_in       (sa_in),
    .sa_in_valid (sa_in_valid)
  );

endmodule

// File: tb/tb_brightness_tpu_scheduler.sv
// Directed bench for brightness_tpu_scheduler with a behavioural array model (lane + weight).
module tb_brightness_tpu_scheduler;

  localparam int D  = 4;
  localparam int W  = 16;
  localparam int AW = 6;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [7:0]     bright_offset = 8'h00;
  logic [W*D-1:0] blk_data = '0;
  logic           blk_valid = 1'b0;
  logic           blk_last = 1'b0;
  logic           tpu_ready;
  logic [W*D-1:0] sa_in;
  logic [D-1:0]   sa_in_valid;
  logic [W-1:0]   sa_weight;
  logic [W*D-1:0] sa_out;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [7:0]     wr_data;
  logic           busy;
  logic           done;

  int total = 0;
  int bad   = 0;

  logic [W-1:0]   model_q [D];
  logic           ovr_en = 1'b0;
  logic [W*D-1:0] ovr_val = '0;

  logic [AW-1:0]  wa_q [$];
  logic [7:0]     wd_q [$];
  logic [D-1:0]   vld_q [$];
  int hs_cnt = 0;
  int done_cnt = 0;

  logic [7:0] exp1 [D];
  logic [7:0] exps [D];

  brightness_tpu_scheduler #(
    .DEPTH          (D),
    .PE_DATA_WIDTH  (W),
    .OUT_ADDR_WIDTH (AW),
    .DRAIN_CYCLES   (2*D-1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .bright_offset (bright_offset),
    .blk_data      (blk_data),
    .blk_valid     (blk_valid),
    .blk_last      (blk_last),
    .tpu_ready     (tpu_ready),
    .sa_in         (sa_in),
    .sa_in_valid   (sa_in_valid),
    .sa_weight     (sa_weight),
    .sa_out        (sa_out),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < D; i++) model_q[i] <= '0;
    end else begin
      for (int i = 0; i < D; i++)
        if (sa_in_valid[i]) model_q[i] <= sa_in[i*W +: W] + sa_weight;
    end
  end

  always_comb begin
    sa_out = ovr_val;
    if (!ovr_en)
      for (int i = 0; i < D; i++) sa_out[i*W +: W] = model_q[i];
  end

  always @(posedge clk) begin
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
    if (|sa_in_valid) vld_q.push_back(sa_in_valid);
    if (tpu_ready && blk_valid) hs_cnt++;
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Counts falling edges until done is seen (bounded).
  task automatic wait_done(input string tag, input int exp_n);
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n, exp_n);
  endtask

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    vld_q.delete();
    hs_cnt   = 0;
    done_cnt = 0;
  endtask

  initial begin
    exp1[0] = 8'h2A; exp1[1] = 8'h34; exp1[2] = 8'h3E; exp1[3] = 8'h48;
    exps[0] = 8'hFF; exps[1] = 8'hFF; exps[2] = 8'hFF; exps[3] = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst tpu_ready", tpu_ready, 0);
    chk("rst busy", busy, 0);
    chk("rst wr_en", wr_en, 0);
    chk("rst done", done, 0);
    chk("rst sa_in_valid", sa_in_valid, 0);
    chk("rst sa_in", sa_in[31:0], 0);
    chk("rst sa_weight", sa_weight, 0);
    chk("rst wr_addr", wr_addr, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single frame, offset 0x20, block {10,20,30,40}
    clear_mon();
    start = 1'b1; bright_offset = 8'h20;
    @(negedge clk);
    start = 1'b0;
    chk("arm tpu_ready", tpu_ready, 1);
    chk("arm busy", busy, 1);
    chk("arm sa_weight", sa_weight, 16'h0020);
    blk_data = {16'd40, 16'd30, 16'd20, 16'd10};
    blk_valid = 1'b1; blk_last = 1'b1;
    wait_done("f1 done latency", 16);
    blk_valid = 1'b0;
    @(negedge clk);
    chk("f1 done width", done, 0);
    chk("f1 idle busy", busy, 0);
    chk("f1 handshakes", hs_cnt, 1);
    chk("f1 done count", done_cnt, 1);
    chk("f1 write count", wa_q.size(), D);
    chk("f1 strobe count", vld_q.size(), D);
    for (int i = 0; i < D; i++) begin
      if (i < wa_q.size()) begin
        chk("f1 wr_addr", wa_q[i], i);
        chk("f1 wr_data", wd_q[i], exp1[i]);
      end
      if (i < vld_q.size()) chk("f1 sa_in_valid", vld_q[i], 1 << i);
    end

    // Reset while feeding lane 2
    clear_mon();
    start = 1'b1; bright_offset = 8'h11;
    @(negedge clk);
    start = 1'b0;
    blk_data = {16'd4, 16'd3, 16'd2, 16'd1};
    blk_valid = 1'b1; blk_last = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("feed lane2 strobe", sa_in_valid, 4'b0100);
    reset = 1'b1;
    #1;
    chk("midrst sa_in_valid", sa_in_valid, 0);
    chk("midrst tpu_ready", tpu_ready, 0);
    chk("midrst busy", busy, 0);
    chk("midrst sa_weight", sa_weight, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst no writes", wa_q.size(), 0);
    chk("midrst stays idle", busy, 0);
    chk("midrst no done", done_cnt, 0);

    // Saturation, plus a start pulse during DRAIN that must be ignored
    clear_mon();
    ovr_en = 1'b1;
    ovr_val = {16'h0000, 16'hFFFF, 16'h00FF, 16'h0100};
    start = 1'b1; bright_offset = 8'h07;
    @(negedge clk);
    start = 1'b0;
    blk_data = {16'd9, 16'd9, 16'd9, 16'd9};
    blk_valid = 1'b1; blk_last = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; bright_offset = 8'h55;
    @(negedge clk);
    start = 1'b0; bright_offset = 8'h00;
    chk("drain start busy", busy, 1);
    chk("drain start ready", tpu_ready, 0);
    chk("drain start weight", sa_weight, 16'h0007);
    wait_done("sat done latency", 9);
    @(negedge clk);
    chk("sat write count", wa_q.size(), D);
    for (int i = 0; i < D; i++) begin
      if (i < wa_q.size()) begin
        chk("sat wr_addr", wa_q[i], i);
        chk("sat wr_data", wd_q[i], exps[i]);
      end
    end
    chk("sat weight kept", sa_weight, 16'h0007);
    chk("sat idle busy", busy, 0);
    ovr_en = 1'b0;

    // 17 blocks with valid held throughout; addresses wrap 63 -> 0
    clear_mon();
    start = 1'b1; bright_offset = 8'h10;
    @(negedge clk);
    start = 1'b0;
    blk_valid = 1'b1; blk_last = 1'b0;
    for (int b = 0; b < 17; b++) begin
      int n;
      n = 0;
      while (!tpu_ready && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (b > 0) chk("bp ready gap", n, 15);
      if (b == 16) chk("no early done", done_cnt, 0);
      for (int l = 0; l < D; l++) blk_data[l*W +: W] = 16'(b*D + l);
      blk_last = (b == 16);
      @(negedge clk);
    end
    wait_done("multi done latency", 15);
    @(negedge clk);
    blk_valid = 1'b0; blk_last = 1'b0;
    chk("multi handshakes", hs_cnt, 17);
    chk("multi done count", done_cnt, 1);
    chk("multi write count", wa_q.size(), 17*D);
    for (int i = 0; i < wa_q.size(); i++) begin
      chk("multi wr_addr", wa_q[i], i % 64);
      chk("multi wr_data", wd_q[i], i + 16);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/brightness_tpu_scheduler.md
# brightness_tpu_scheduler

Sequences the 4x4 systolic brightness array between the RAM block loader and the result RAM. Accepts one DEPTH-pixel block per handshake and feeds it into the array one lane per cycle. Waits out the array drain latency, then writes the saturated 8-bit results sequentially to the output RAM. Re-arms `tpu_ready` so the loader can deliver the next block.

## Interface
- `DEPTH`, 4: array dimension, i.e. pixels per block.
- `PE_DATA_WIDTH`, 16: lane width into and out of the array.
- `OUT_ADDR_WIDTH`, 6: result RAM address width.
- `DRAIN_CYCLES`, 7 (2*DEPTH-1): cycles from last lane fed to valid `sa_out`.

- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `start` in 1: begin a frame; sampled in IDLE only.
- `bright_offset` in 8: brightness weight; latched on accepted `start`.
- `blk_data` in PE_DATA_WIDTH*DEPTH: pixel block, lane 0 in the LSBs.
- `blk_valid` in 1: block present.
- `blk_last` in 1: qualifies the final block of the frame; sampled with `blk_valid`.
- `tpu_ready` out 1: scheduler can accept a block.
- `sa_in` out PE_DATA_WIDTH*DEPTH: array lane inputs.
- `sa_in_valid` out DEPTH: one-hot lane strobe.
- `sa_weight` out PE_DATA_WIDTH: `{8'h00, offset_q}`, held for the whole frame.
- `sa_out` in PE_DATA_WIDTH*DEPTH: array results, lane 0 in the LSBs.
- `wr_en` out 1: result RAM write strobe.
- `wr_addr` out OUT_ADDR_WIDTH: result RAM address.
- `wr_data` out 8: saturated result.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at frame end.

## Operation
- States: IDLE, ARM, FEED, DRAIN, WRITE, DONE_ST.
- IDLE -> ARM on `start`.
  - On that edge: latch `bright_offset`; clear `wr_addr` to 0.
- ARM: `tpu_ready`=1.
  - Handshake is `tpu_ready && blk_valid` at a rising edge.
  - On the handshake: capture `blk_data` into `in_buf[DEPTH]`, capture `blk_last` into `last_q`, go to FEED.
- FEED: lane counter k = 0..DEPTH-1.
  - `sa_in` lane k = `in_buf[k]`; all other lanes are 0.
  - `sa_in_valid` = 1<<k.
  - After k = DEPTH-1, go to DRAIN.
- DRAIN: count DRAIN_CYCLES cycles.
  - On the last DRAIN cycle, capture `sa_out` into `res_buf`.
  - Then go to WRITE.
- WRITE: index j = 0..DEPTH-1.
  - `wr_en`=1, `wr_data` = sat8(`res_buf[j]`), `wr_addr` increments after each write.
  - sat8(x) = x > 255 ? 8'hFF : x[7:0].
  - After j = DEPTH-1: go to DONE_ST if `last_q`, otherwise go to ARM.
- DONE_ST: `done`=1 for one cycle, then go to IDLE.
- `wr_addr` wraps modulo 2^OUT_ADDR_WIDTH with no error indication.
- Ignored inputs:
  - `start` outside IDLE.
  - `blk_valid` outside ARM, because `tpu_ready`=0 there.
  - `bright_offset` changes mid-frame.
- Reset (at any time, including mid-block):
  - Go to IDLE.
  - All outputs 0, including `tpu_ready`, `wr_en`, `done`, `busy`, `sa_in`, `sa_in_valid`, `sa_weight`.
  - Buffers and counters cleared; no partial write completes.

## Timing
- Handshake edge T:
  - FEED occupies cycles T+1..T+DEPTH.
  - DRAIN occupies the next DRAIN_CYCLES cycles.
  - WRITE occupies the next DEPTH cycles.
- Per-block occupancy is DEPTH+DRAIN_CYCLES+DEPTH = 15 cycles at defaults.
- `tpu_ready` reasserts the cycle after the last write, or `done` pulses then if `last_q`.
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- `tpu_ready` is a level signal, compatible with a loader that holds its block valid while waiting.

## Structure
- Shared package `brightness_pkg`:
  - state enum `sched_state_t`.
  - `DEPTH`/`PE_DATA_WIDTH` defaults.
  - function `sat8`.
- Sub-module `lane_feeder`: holds `in_buf` and drives `sa_in`/`sa_in_valid` from lane index k.
- Top module holds the FSM, drain counter, `res_buf` and the write port.

## Test plan
- Reset mid-FEED (lane 2) -> next cycle IDLE; `sa_in_valid`=0, `tpu_ready`=0, `busy`=0; no `wr_en` follows.
- Single frame: `start` with `bright_offset`=8'h20, one block {10,20,30,40} with `blk_last`=1, array model adds the weight:
  - `sa_in_valid` sequence 0001, 0010, 0100, 1000.
  - Writes 0x2A, 0x34, 0x3E, 0x48 at addresses 0..3.
  - `done` pulses 16 cycles after the handshake.
- Saturation: array model returns {0x0100, 0x00FF, 0xFFFF, 0x0000} -> `wr_data` FF, FF, FF, 00.
- Back-pressure: `blk_valid` held during FEED/DRAIN/WRITE -> no second capture; exactly one block accepted per ARM visit; `tpu_ready` low for 15 cycles.
- Multi-block with wrap: 17 blocks (68 writes) with OUT_ADDR_WIDTH=6 -> `wr_addr` wraps 63 -> 0; `done` only after block 17.
- Ignored `start`: `start` pulsed during DRAIN -> no state change, offset unchanged.
